// File: rtl/craps_game_ctrl_pkg.sv
// Shared definitions for the craps game sequencer: state encodings,
// rule sums and the die legality helper.
package craps_game_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROLL   = 3'd1,
    S_SETTLE = 3'd2,
    S_EVAL   = 3'd3,
    S_POINT  = 3'd4,
    S_WIN    = 3'd5,
    S_LOSE   = 3'd6
  } state_t;

  localparam logic [3:0] WIN_7    = 4'd7;
  localparam logic [3:0] WIN_11   = 4'd11;
  localparam logic [3:0] CRAPS_2  = 4'd2;
  localparam logic [3:0] CRAPS_3  = 4'd3;
  localparam logic [3:0] CRAPS_12 = 4'd12;
  localparam logic [2:0] DIE_MIN  = 3'd1;
  localparam logic [2:0] DIE_MAX  = 3'd6;

  function automatic logic die_legal(input logic [2:0] d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage

// File: rtl/craps_game_ctrl_if.sv
// Board-side and dice-side signals of the craps sequencer; master is the
// controller, slave is the board/dice logic driving buttons and die values.
interface craps_game_ctrl_if;

  logic       roll_btn;
  logic       new_game;
  logic [2:0] die1;
  logic [2:0] die2;
  logic       dice_en;
  logic [3:0] sum;
  logic [3:0] point;
  logic       point_valid;
  logic       win;
  logic       lose;
  logic       dice_err;
  logic [7:0] roll_count;
  logic [2:0] state;

  modport master (
    input  roll_btn, new_game, die1, die2,
    output dice_en, sum, point, point_valid, win, lose, dice_err,
           roll_count, state
  );

  modport slave (
    output roll_btn, new_game, die1, die2,
    input  dice_en, sum, point, point_valid, win, lose, dice_err,
           roll_count, state
  );

endinterface

// File: rtl/craps_game_ctrl_btn_sync_edge.sv
// Two-flop synchronizer with rising-edge pulse for a raw board button.
// An edge only counts after the synced level has been seen low, so a
// button held through reset or a clear never produces a press.
module craps_game_ctrl_btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic level,
  output logic rise
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic       armed;
  logic [1:0] fill;

  // fill marks when the sync pipeline holds real samples rather than reset zeros
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      fill  <= 2'b00;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
      fill <= {fill[0], 1'b1};
      if (clear)
        armed <= 1'b0;
      else if (fill[1] && !sync)
        armed <= 1'b1;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev & armed;

endmodule

// File: rtl/craps_game_ctrl.sv
// Craps game sequencer: runs the dice while the roll button is held,
// captures and sums the dice, and applies come-out and point rules.
module craps_game_ctrl #(
  parameter int MIN_ROLL_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 4
) (
  input logic               clock,
  input logic               reset,
  craps_game_ctrl_if.master bus
);
  import craps_game_ctrl_pkg::*;

  localparam int MAX_CYC = (MIN_ROLL_CYCLES > SETTLE_CYCLES) ? MIN_ROLL_CYCLES : SETTLE_CYCLES;
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ROLL_LAST   = CW'(MIN_ROLL_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    cap1_q, cap2_q;
  logic [3:0]    sum_q, point_q, roll_sum;
  logic          point_valid_q, dice_err_q;
  logic [7:0]    roll_count_q;
  logic          btn_level, press;
  logic          capture, do_eval, set_point, cap_err;

  craps_game_ctrl_btn_sync_edge u_roll_btn (
    .clock (clock),
    .reset (reset),
    .btn   (bus.roll_btn),
    .clear (bus.new_game),
    .level (btn_level),
    .rise  (press)
  );

  assign roll_sum = 4'(cap1_q) + 4'(cap2_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_eval   = 1'b0;
    set_point = 1'b0;
    cap_err   = 1'b0;
    if (bus.new_game) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_POINT: begin
          if (press) begin
            state_d = S_ROLL;
            cnt_d   = '0;
          end
        end
        // the hold counter saturates at the minimum so long presses never wrap
        S_ROLL: begin
          if (!btn_level && cnt_q >= ROLL_LAST) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q < ROLL_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q >= SETTLE_LAST) begin
            cnt_d   = '0;
            capture = 1'b1;
            if (die_legal(bus.die1) && die_legal(bus.die2)) begin
              state_d = S_EVAL;
            end else begin
              cap_err = 1'b1;
              state_d = point_valid_q ? S_POINT : S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_EVAL: begin
          do_eval = 1'b1;
          if (!point_valid_q) begin
            if (roll_sum == WIN_7 || roll_sum == WIN_11)
              state_d = S_WIN;
            else if (roll_sum == CRAPS_2 || roll_sum == CRAPS_3 || roll_sum == CRAPS_12)
              state_d = S_LOSE;
            else begin
              state_d   = S_POINT;
              set_point = 1'b1;
            end
          end else begin
            if (roll_sum == point_q)
              state_d = S_WIN;
            else if (roll_sum == WIN_7)
              state_d = S_LOSE;
            else
              state_d = S_POINT;
          end
        end
        S_WIN, S_LOSE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cap1_q        <= '0;
      cap2_q        <= '0;
      sum_q         <= '0;
      point_q       <= '0;
      point_valid_q <= 1'b0;
      dice_err_q    <= 1'b0;
      roll_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dice_err_q <= cap_err;
      if (capture) begin
        cap1_q <= bus.die1;
        cap2_q <= bus.die2;
      end
      if (bus.new_game) begin
        point_q       <= '0;
        point_valid_q <= 1'b0;
        roll_count_q  <= '0;
      end else if (do_eval) begin
        sum_q <= roll_sum;
        if (roll_count_q != 8'hFF)
          roll_count_q <= roll_count_q + 8'd1;
        if (set_point) begin
          point_q       <= roll_sum;
          point_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dice_en     = (state_q == S_ROLL);
  assign bus.win         = (state_q == S_WIN);
  assign bus.lose        = (state_q == S_LOSE);
  assign bus.state       = state_q;
  assign bus.sum         = sum_q;
  assign bus.point       = point_q;
  assign bus.point_valid = point_valid_q;
  assign bus.dice_err    = dice_err_q;
  assign bus.roll_count  = roll_count_q;

endmodule

// File: tb/tb_craps_game_ctrl.sv
// Self-checking bench for craps_game_ctrl: directed game scenarios plus
// random rolls scored against a rule-level model of the game.
module tb_craps_game_ctrl;

  localparam int MIN_ROLL   = 16;
  localparam int SETTLE     = 4;
  localparam int PH_COMEOUT = 0;
  localparam int PH_POINT   = 1;
  localparam int PH_WON     = 2;
  localparam int PH_LOST    = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  craps_game_ctrl_if bus();

  craps_game_ctrl #(
    .MIN_ROLL_CYCLES (MIN_ROLL),
    .SETTLE_CYCLES   (SETTLE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int en_cur      = 0;
  int en_last     = 0;
  int en_runs     = 0;
  int err_pulses  = 0;

  int m_phase;
  int m_point;
  int m_sum;
  int m_rc;
  bit m_pv;

  // Measures each dice_en run length and counts dice_err cycles.
  always @(posedge clock) begin
    #1;
    if (bus.dice_en)
      en_cur++;
    else if (en_cur != 0) begin
      en_last = en_cur;
      en_runs++;
      en_cur  = 0;
    end
    if (bus.dice_err)
      err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset(input bit clear_sum);
    m_phase = PH_COMEOUT;
    m_point = 0;
    m_pv    = 1'b0;
    m_rc    = 0;
    if (clear_sum)
      m_sum = 0;
  endtask

  function automatic bit legalDie(input int d);
    return (d >= 1) && (d <= 6);
  endfunction

  task automatic modelRoll(input int d1, input int d2);
    int s;
    if (legalDie(d1) && legalDie(d2)) begin
      s     = d1 + d2;
      m_sum = s;
      if (m_rc < 255)
        m_rc++;
      if (m_phase == PH_COMEOUT) begin
        if (s == 7 || s == 11)
          m_phase = PH_WON;
        else if (s == 2 || s == 3 || s == 12)
          m_phase = PH_LOST;
        else begin
          m_phase = PH_POINT;
          m_point = s;
          m_pv    = 1'b1;
        end
      end else if (s == m_point)
        m_phase = PH_WON;
      else if (s == 7)
        m_phase = PH_LOST;
    end
  endtask

  task automatic checkOutput(input string ctx);
    int exp_state;
    case (m_phase)
      PH_COMEOUT: exp_state = 0;
      PH_POINT:   exp_state = 4;
      PH_WON:     exp_state = 5;
      default:    exp_state = 6;
    endcase
    check({ctx, ".state"},       32'(bus.state),       32'(exp_state));
    check({ctx, ".dice_en"},     32'(bus.dice_en),     32'd0);
    check({ctx, ".sum"},         32'(bus.sum),         32'(m_sum));
    check({ctx, ".point"},       32'(bus.point),       32'(m_point));
    check({ctx, ".point_valid"}, 32'(bus.point_valid), 32'(m_pv));
    check({ctx, ".win"},         32'(bus.win),         32'(m_phase == PH_WON));
    check({ctx, ".lose"},        32'(bus.lose),        32'(m_phase == PH_LOST));
    check({ctx, ".roll_count"},  32'(bus.roll_count),  32'(m_rc));
  endtask

  function automatic bit settled();
    return !bus.dice_en && (bus.state == 3'd0 || bus.state == 3'd4 ||
                            bus.state == 3'd5 || bus.state == 3'd6);
  endfunction

  // One button press with the given dice; a press in a finished game must do nothing.
  task automatic applyStimulus(input string ctx, input int hold, input int d1, input int d2);
    int runs0, errs0, waited;
    bit rolls;
    rolls    = (m_phase == PH_COMEOUT) || (m_phase == PH_POINT);
    runs0    = en_runs;
    errs0    = err_pulses;
    bus.die1 = 3'(d1);
    bus.die2 = 3'(d2);
    @(negedge clock);
    bus.roll_btn = 1'b1;
    repeat (hold) @(negedge clock);
    bus.roll_btn = 1'b0;
    if (rolls) begin
      waited = 0;
      while (!(en_runs > runs0 && settled()) && waited < 200) begin
        @(negedge clock);
        waited++;
      end
      check({ctx, ".done"},   32'(waited < 200), 32'd1);
      check({ctx, ".en_len"}, 32'(en_last), 32'((hold > MIN_ROLL) ? hold : MIN_ROLL));
      check({ctx, ".err"},    32'(err_pulses - errs0),
            32'((legalDie(d1) && legalDie(d2)) ? 0 : 1));
      modelRoll(d1, d2);
    end else begin
      repeat (40) @(negedge clock);
      check({ctx, ".ignored"}, 32'(en_runs - runs0 + en_cur), 32'd0);
    end
    checkOutput(ctx);
  endtask

  task automatic newGame(input string ctx);
    @(negedge clock);
    bus.new_game = 1'b1;
    @(negedge clock);
    bus.new_game = 1'b0;
    modelReset(1'b0);
    checkOutput(ctx);
  endtask

  function automatic int randDie();
    int v;
    v = int'($urandom_range(0, 15));
    if (v < 14) return (v % 6) + 1;
    return (v == 14) ? 0 : 7;
  endfunction

  initial begin
    int runs0, waited;
    bus.roll_btn = 1'b0;
    bus.new_game = 1'b0;
    bus.die1     = 3'd1;
    bus.die2     = 3'd1;
    modelReset(1'b1);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset");
    check("reset.dice_err", 32'(bus.dice_err), 32'd0);

    applyStimulus("come_out_7", 2, 3, 4);
    applyStimulus("win_press_ignored", 3, 1, 1);

    newGame("ng1");
    applyStimulus("come_out_2", 2, 1, 1);
    newGame("ng2");

    applyStimulus("point_4", 5, 2, 2);
    applyStimulus("seven_out", 2, 5, 2);
    newGame("ng3");
    applyStimulus("point_4b", 2, 2, 2);
    applyStimulus("bad_die_in_point", 2, 0, 3);
    applyStimulus("make_point", 2, 1, 3);

    // Button held while new_game clears a finished game must not roll.
    @(negedge clock);
    bus.roll_btn = 1'b1;
    repeat (3) @(negedge clock);
    runs0 = en_runs;
    newGame("ng_held");
    repeat (30) @(negedge clock);
    check("ng_held.no_roll", 32'(en_runs - runs0 + en_cur), 32'd0);
    bus.roll_btn = 1'b0;
    repeat (4) @(negedge clock);

    // new_game coinciding with the synced press discards that press.
    runs0 = en_runs;
    @(negedge clock);
    bus.roll_btn = 1'b1;
    repeat (2) @(negedge clock);
    bus.new_game = 1'b1;
    @(negedge clock);
    bus.new_game = 1'b0;
    repeat (30) @(negedge clock);
    check("ng_press.no_roll", 32'(en_runs - runs0 + en_cur), 32'd0);
    bus.roll_btn = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("ng_press");

    applyStimulus("long_press", 20, 6, 5);
    newGame("ng4");

    // Reset in the middle of a roll clears every output at once.
    @(negedge clock);
    bus.roll_btn = 1'b1;
    waited = 0;
    while (!bus.dice_en && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("midroll.started", 32'(bus.dice_en), 32'd1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midroll.dice_en",     32'(bus.dice_en),     32'd0);
    check("midroll.state",       32'(bus.state),       32'd0);
    check("midroll.sum",         32'(bus.sum),         32'd0);
    check("midroll.point",       32'(bus.point),       32'd0);
    check("midroll.point_valid", 32'(bus.point_valid), 32'd0);
    check("midroll.win_lose",    32'({bus.win, bus.lose}), 32'd0);
    check("midroll.dice_err",    32'(bus.dice_err),    32'd0);
    check("midroll.roll_count",  32'(bus.roll_count),  32'd0);
    modelReset(1'b1);

    // Button still held as reset releases: no roll until a fresh press.
    repeat (2) @(negedge clock);
    runs0 = en_runs;
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("rst_held.no_roll", 32'(en_runs - runs0 + en_cur), 32'd0);
    bus.roll_btn = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("rst_held");

    applyStimulus("bad_die_come_out", 2, 4, 7);

    // Hold a point of 4 with sixes until the roll counter saturates.
    applyStimulus("sat_point", 1, 1, 3);
    for (int i = 0; i < 258; i++)
      applyStimulus("sat_roll", 1, 3, 3);
    check("sat.roll_count", 32'(bus.roll_count), 32'd255);
    newGame("ng5");

    for (int i = 0; i < 40; i++) begin
      if (m_phase == PH_WON || m_phase == PH_LOST)
        newGame("rand_ng");
      applyStimulus("rand", int'($urandom_range(1, 24)), randDie(), randDie());
    end

    $display("[TB] run complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
